// File: rtl/pipeline_stage_elastic.sv
// Two-entry elastic pipeline stage (main + skid) with valid/ready handshake,
// hazard-unit stall/flush control, NOP bubble injection and a saturating stall counter.
module pipeline_stage_elastic #(
    parameter int unsigned          DATA_W       = 128,
    parameter int unsigned          CTRL_W       = 16,
    parameter logic [CTRL_W-1:0]    BUBBLE_CTRL  = '0,
    parameter bit                   FLUSH_BUBBLE = 1'b1,
    parameter int unsigned          CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CTRL_W-1:0]  main_ctrl, main_ctrl_n;
    logic [DATA_W-1:0]  main_data, main_data_n;
    logic [CTRL_W-1:0]  skid_ctrl, skid_ctrl_n;
    logic [DATA_W-1:0]  skid_data, skid_data_n;
    logic               skid_valid;
    logic               push;
    logic               pop;

    assign out_valid  = (state != EMPTY);
    assign skid_valid = (state == FULL);
    assign occupancy  = state;
    assign out_ctrl   = main_ctrl;
    assign out_data   = main_data;

    // Readiness depends only on local state and hazard controls, never on out_ready.
    assign in_ready = !skid_valid && !stall && !flush && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready && !stall;

    always_comb begin
        state_n     = state;
        main_ctrl_n = main_ctrl;
        main_data_n = main_data;
        skid_ctrl_n = skid_ctrl;
        skid_data_n = skid_data;
        if (flush) begin
            state_n     = FLUSH_BUBBLE ? ONE : EMPTY;
            main_ctrl_n = BUBBLE_CTRL;
            main_data_n = '0;
            skid_ctrl_n = '0;
            skid_data_n = '0;
        end else if (!stall) begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_n     = ONE;
                        main_ctrl_n = in_ctrl;
                        main_data_n = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_ctrl_n = in_ctrl;
                        main_data_n = in_data;
                    end else if (push) begin
                        state_n     = FULL;
                        skid_ctrl_n = in_ctrl;
                        skid_data_n = in_data;
                    end else if (pop) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_n     = ONE;
                        main_ctrl_n = skid_ctrl;
                        main_data_n = skid_data;
                        skid_ctrl_n = '0;
                        skid_data_n = '0;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_n;
            main_ctrl <= main_ctrl_n;
            main_data <= main_data_n;
            skid_ctrl <= skid_ctrl_n;
            skid_data <= skid_data_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && out_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Scoreboard bench: stimulus pushes expected transfers into a queue, a negedge monitor
// pops and compares on every downstream handshake.
module tb_pipeline_stage_elastic;

    localparam int unsigned DW = 128;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] BUB = 16'h0013;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    logic          clk;
    logic          rst;
    logic          stall;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          rdy0, rdy1, rdy2;
    logic          ov0, ov1, ov2;
    logic [CW-1:0] oc0, oc1, oc2;
    logic [DW-1:0] od0, od1, od2;
    logic [1:0]    occ0, occ1, occ2;
    logic [15:0]   cnt0, cnt1;
    logic [2:0]    cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    item_t q[$];
    int    mocc0, mocc1;
    int    mcnt0, mcnt2;

    pipeline_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB),
                             .FLUSH_BUBBLE(1'b1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .occupancy(occ0), .stall_cnt(cnt0));

    pipeline_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB),
                             .FLUSH_BUBBLE(1'b0), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .occupancy(occ1), .stall_cnt(cnt1));

    pipeline_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB),
                             .FLUSH_BUBBLE(1'b1), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy2), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_ctrl(oc2), .out_data(od2),
        .occupancy(occ2), .stall_cnt(cnt2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every downstream handshake on u0 must match the queue head.
    always @(negedge clk) begin
        if (!rst && ov0 && out_ready && !stall) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {oc0, od0[DW-CW-1:0]}, '0);
            end else begin
                item_t e;
                e = q.pop_front();
                chk("out_ctrl", DW'(oc0), DW'(e.c));
                chk("out_data", od0, e.d);
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit ordy, input bit stl, input bit fl);
        bit r0, r1, push0, push1, pop0, pop1;
        int old0;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
        r0    = (mocc0 < 2) && !stl && !fl;
        r1    = (mocc1 < 2) && !stl && !fl;
        push0 = v && r0;
        push1 = v && r1;
        pop0  = (mocc0 > 0) && ordy && !stl;
        pop1  = (mocc1 > 0) && ordy && !stl;
        if (push0) q.push_back('{c: c, d: d});
        #4;
        chk("in_ready_u0", DW'(rdy0), DW'(r0));
        chk("in_ready_u1", DW'(rdy1), DW'(r1));
        @(posedge clk);
        #1;
        old0 = mocc0;
        if (fl) begin
            q.delete();
            q.push_back('{c: BUB, d: '0});
            mocc0 = 1;
            mocc1 = 0;
        end else begin
            mocc0 = mocc0 + int'(push0) - int'(pop0);
            mocc1 = mocc1 + int'(push1) - int'(pop1);
        end
        if (stl && old0 > 0) begin
            if (mcnt0 < 65535) mcnt0++;
            if (mcnt2 < 7) mcnt2++;
        end
        chk("occupancy_u0", DW'(occ0), DW'(mocc0));
        chk("occupancy_u1", DW'(occ1), DW'(mocc1));
        chk("out_valid_u0", DW'(ov0), DW'(mocc0 > 0));
        chk("out_valid_u1", DW'(ov1), DW'(mocc1 > 0));
        chk("stall_cnt_u0", DW'(cnt0), DW'(mcnt0));
        chk("stall_cnt_u2", DW'(cnt2), DW'(mcnt2));
    endtask

    // One reset cycle with an upstream push offered, which must be refused.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 16'hdead;
        in_data   = 128'hbad;
        out_ready = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        #4;
        chk("rst_in_ready_u0", DW'(rdy0), '0);
        chk("rst_in_ready_u2", DW'(rdy2), '0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", DW'(ov0), '0);
        chk("rst_out_ctrl", DW'(oc0), '0);
        chk("rst_out_data", od0, '0);
        chk("rst_occupancy", DW'(occ0), '0);
        chk("rst_stall_cnt_u0", DW'(cnt0), '0);
        chk("rst_stall_cnt_u2", DW'(cnt2), '0);
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        mocc0 = 0;
        mocc1 = 0;
        mcnt0 = 0;
        mcnt2 = 0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        mocc0 = 0; mocc1 = 0; mcnt0 = 0; mcnt2 = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Single transfer with 1-cycle latency, then drain.
        step(1, 16'h0001, 128'h1111, 1, 0, 0);
        chk("lat_out_data", od0, 128'h1111);
        step(0, '0, '0, 1, 0, 0);

        // Backpressure fills main + skid; third offer refused; FIFO drain.
        step(1, 16'h0001, 128'h1111, 0, 0, 0);
        step(1, 16'h0002, 128'h2222, 0, 0, 0);
        chk("full_out_data", od0, 128'h1111);
        step(1, 16'h0003, 128'h3333, 0, 0, 0);
        step(0, '0, '0, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // Back-to-back streaming at full throughput.
        for (int i = 0; i < 4; i++)
            step(1, CW'(16'h0100 + i), DW'(128'hA000 + i), 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // Stall holds contents, blocks push, ignores out_ready.
        do_reset();
        step(1, 16'h0001, 128'h1111, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1, 16'h0044, 128'h4444, 1, 1, 0);
        chk("stall_hold_data", od0, 128'h1111);
        chk("stall_cnt_5", DW'(cnt0), DW'(5));
        step(0, '0, '0, 1, 0, 0);

        // Flush while FULL: bubble on u0, empty on u1.
        step(1, 16'h0001, 128'h1111, 0, 0, 0);
        step(1, 16'h0002, 128'h2222, 0, 0, 0);
        step(0, '0, '0, 0, 0, 1);
        chk("flush_ctrl", DW'(oc0), DW'(BUB));
        chk("flush_data", od0, '0);
        // Bubble pops while a new transfer is pushed in the same cycle.
        step(1, 16'h0005, 128'h5555, 1, 0, 0);
        step(0, '0, '0, 1, 0, 0);

        // Stall and flush together: flush wins, offered push is dropped.
        step(1, 16'h0001, 128'h1111, 0, 0, 0);
        step(1, 16'h0006, 128'h6666, 1, 1, 1);
        step(0, '0, '0, 1, 0, 0);

        // Flush with a simultaneous pop: head counted as delivered, not re-presented.
        step(1, 16'h0007, 128'h7777, 0, 0, 0);
        step(0, '0, '0, 1, 0, 1);
        step(0, '0, '0, 1, 0, 0);

        // Counter saturation on the 3-bit instance.
        do_reset();
        step(1, 16'h0008, 128'h8888, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step(0, '0, '0, 1, 1, 0);
        chk("sat_cnt_u2", DW'(cnt2), DW'(7));
        chk("sat_cnt_u0", DW'(cnt0), DW'(10));
        step(0, '0, '0, 1, 0, 0);
        do_reset();

        chk("scoreboard_drained", DW'(q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
